irq_ctrl: RTL and testbench

- Parametrised multi-channel interrupt controller between peripheral interrupt sources (UART rx, timers, buttons) and the CPU core.
- Replaces the single irr/ack pair with N latched, maskable, priority-encoded channels and a per-channel edge/level mode.
- Hands the core one request at a time through a registered irr/ack handshake with a channel id.
- Blocks further requests until the core signals end-of-interrupt.

---
 rtl/irq_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Multi-channel interrupt controller.
// Latches edge- or level-triggered requests per channel, masks them with a
// software-written enable, and hands the lowest-index pending channel to the
// core through a registered irr/ack handshake. The next request waits until
// the core signals end-of-interrupt.
module irq_ctrl #(
   parameter int               N_IRQ     = 4,
   parameter logic [N_IRQ-1:0] EDGE_MASK = {N_IRQ{1'b1}},
   localparam int              ID_W      = $clog2(N_IRQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] src,
   input  logic             en_we,
   input  logic [N_IRQ-1:0] en_wdata,
   output logic             irr,
   output logic [ID_W-1:0]  irq_id,
   input  logic             ack,
   input  logic             eoi,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] enable,
   output logic             in_service
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t            state_reg, state_next;
   logic              irr_reg, irr_next;
   logic [ID_W-1:0]   irq_id_reg, irq_id_next;
   logic              in_service_reg, in_service_next;
   logic [N_IRQ-1:0]  pending_reg, pending_next;
   logic [N_IRQ-1:0]  enable_reg;
   logic [N_IRQ-1:0]  src_q_reg;
   logic [N_IRQ-1:0]  set_cond;
   logic [N_IRQ-1:0]  ack_clr;
   logic [N_IRQ-1:0]  req_vec;
   logic [ID_W-1:0]   req_id;

   // Per-channel set/clear. A set in the same cycle as the clearing ack wins,
   // so a fresh edge or a still-high level is never dropped.
   genvar gi;
   generate
      for (gi = 0; gi < N_IRQ; gi++) begin : g_chan
         if (EDGE_MASK[gi]) begin : g_edge
            assign set_cond[gi] = src[gi] & ~src_q_reg[gi];
         end else begin : g_level
            assign set_cond[gi] = src[gi];
         end
         assign ack_clr[gi]      = (state_reg == REQ) && ack && (irq_id_reg == ID_W'(gi));
         assign pending_next[gi] = set_cond[gi] | (pending_reg[gi] & ~ack_clr[gi]);
      end
   endgenerate

   assign req_vec = pending_reg & enable_reg;

   // Priority encoder: lowest set index has the highest priority.
   always_comb begin
      req_id = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req_vec[i]) req_id = ID_W'(i);
      end
   end

   // Next-state and registered-output values of the handshake FSM.
   always_comb begin
      state_next      = state_reg;
      irr_next        = irr_reg;
      irq_id_next     = irq_id_reg;
      in_service_next = in_service_reg;
      case (state_reg)
         IDLE: begin
            if (req_vec != '0) begin
               state_next  = REQ;
               irr_next    = 1'b1;
               irq_id_next = req_id;
            end
         end
         REQ: begin
            if (ack) begin
               state_next      = SERVICE;
               irr_next        = 1'b0;
               in_service_next = 1'b1;
            end
         end
         SERVICE: begin
            if (eoi) begin
               state_next      = IDLE;
               in_service_next = 1'b0;
            end
         end
         default: begin
            state_next      = IDLE;
            irr_next        = 1'b0;
            in_service_next = 1'b0;
         end
      endcase
   end

   // All state and outputs registered; reset clears everything at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         irr_reg        <= 1'b0;
         irq_id_reg     <= '0;
         in_service_reg <= 1'b0;
         pending_reg    <= '0;
         enable_reg     <= '0;
         src_q_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         irr_reg        <= irr_next;
         irq_id_reg     <= irq_id_next;
         in_service_reg <= in_service_next;
         pending_reg    <= pending_next;
         src_q_reg      <= src;
         if (en_we) enable_reg <= en_wdata;
      end
   end

   assign irr        = irr_reg;
   assign irq_id     = irq_id_reg;
   assign in_service = in_service_reg;
   assign pending    = pending_reg;
   assign enable     = enable_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with channel 0 level-triggered and channels
// 1..3 edge-triggered. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] src;
   logic       en_we;
   logic [3:0] en_wdata;
   logic       irr;
   logic [1:0] irq_id;
   logic       ack;
   logic       eoi;
   logic [3:0] pending;
   logic [3:0] enable;
   logic       in_service;

   int vectors     = 0;
   int miscompares = 0;

   irq_ctrl #(.N_IRQ(4), .EDGE_MASK(4'b1110)) dut (
      .clk        (clk),
      .reset      (reset),
      .src        (src),
      .en_we      (en_we),
      .en_wdata   (en_wdata),
      .irr        (irr),
      .irq_id     (irq_id),
      .ack        (ack),
      .eoi        (eoi),
      .pending    (pending),
      .enable     (enable),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic write_enable(input logic [3:0] m);
      en_we = 1'b1; en_wdata = m;
      tick();
      en_we = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1; tick(); eoi = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pending"},    pending,    0);
      check({tag, ".enable"},     enable,     0);
      check({tag, ".irr"},        irr,        0);
      check({tag, ".irq_id"},     irq_id,     0);
      check({tag, ".in_service"}, in_service, 0);
   endtask

   initial begin
      reset = 1'b1; src = '0; en_we = 1'b0; en_wdata = '0; ack = 1'b0; eoi = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check_all_zero("rst");

      // Single edge on channel 2, full handshake
      write_enable(4'b1111);
      check("t1.enable", enable, 4'b1111);
      src = 4'b0100; tick(); src = '0;
      check("t1.pending", pending, 4'b0100);
      check("t1.irr_early", irr, 0);
      tick();
      check("t1.irr", irr, 1);
      check("t1.id", irq_id, 2);
      do_ack();
      check("t1.pend_ack", pending, 0);
      check("t1.insvc", in_service, 1);
      check("t1.irr_ack", irr, 0);
      do_eoi();
      check("t1.insvc_eoi", in_service, 0);
      tick();
      check("t1.irr_idle", irr, 0);

      // Simultaneous channels 3 and 1: priority order
      src = 4'b1010; tick(); src = '0;
      check("t2.pending", pending, 4'b1010);
      tick();
      check("t2.id_first", irq_id, 1);
      do_ack();
      check("t2.pend_ack", pending, 4'b1000);
      do_eoi();
      check("t2.irr_gap", irr, 0);
      tick();
      check("t2.irr_second", irr, 1);
      check("t2.id_second", irq_id, 3);
      do_ack(); do_eoi();
      check("t2.insvc_end", in_service, 0);

      // Masked pending then enable write
      write_enable(4'b0000);
      src = 4'b0001; tick(); src = '0;
      tick();
      check("t3.pending", pending, 4'b0001);
      check("t3.irr_masked", irr, 0);
      write_enable(4'b0001);
      check("t3.irr_1cyc", irr, 0);
      tick();
      check("t3.irr", irr, 1);
      check("t3.id", irq_id, 0);
      do_ack();
      check("t3.pend_ack", pending, 0);
      do_eoi();

      // Level channel 0 held high re-pends through ack
      write_enable(4'b1111);
      src = 4'b0001; tick();
      tick();
      check("t4.id_lvl", irq_id, 0);
      do_ack();
      check("t4.pend_repend", pending, 4'b0001);
      check("t4.insvc", in_service, 1);
      do_eoi();
      tick();
      check("t4.irr_again", irr, 1);
      check("t4.id_again", irq_id, 0);
      src = '0;
      do_ack();
      check("t4.pend_clr", pending, 0);
      do_eoi();
      tick();
      check("t4.irr_lvl_done", irr, 0);

      // Edge channel 1 held high -> exactly one request
      src = 4'b0010; tick();
      tick();
      check("t4.id_edge", irq_id, 1);
      do_ack();
      check("t4.pend_edge", pending, 0);
      do_eoi();
      tick();
      check("t4.irr_edge_once", irr, 0);
      tick();
      check("t4.pend_edge_once", pending, 0);
      src = '0; tick();

      // New edge on channel 2 in the ack cycle of channel 2
      src = 4'b0100; tick(); src = '0;
      tick();
      check("t5.id", irq_id, 2);
      src = 4'b0100; ack = 1'b1; tick(); src = '0; ack = 1'b0;
      check("t5.pend_kept", pending, 4'b0100);
      check("t5.insvc", in_service, 1);
      do_eoi();
      check("t5.irr_gap", irr, 0);
      tick();
      check("t5.irr_second", irr, 1);
      check("t5.id_second", irq_id, 2);
      do_ack(); do_eoi();
      check("t5.pend_end", pending, 0);

      // Reset while in service with pending 1010
      src = 4'b1010; tick(); src = '0;
      tick();
      do_ack();
      src = 4'b0010; tick(); src = '0;
      check("t6.pending", pending, 4'b1010);
      check("t6.insvc", in_service, 1);
      check("t6.id", irq_id, 1);
      reset = 1'b1; tick(); reset = 1'b0;
      check_all_zero("t6.rst");
      do_ack();
      do_eoi();
      tick();
      check_all_zero("t6.stray");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
